// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core.
// It sequences the datapath mux selects and write enables for lw, sw,
// R-type, I-type ALU, beq and jal. It also drives the 2-bit ALUOp into
// the ALU decoder. It stalls on mem_ready and traps on unknown opcodes.
module multicycle_main_fsm #(
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic       RegWrite,
  output logic       illegal_instr,
  output logic [3:0] state
);

  // State encoding is visible on the debug port, so it is fixed here.
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] state_q;
  logic [3:0] state_d;

  // Un-gated enables. The reset gating and the branch term are applied at the ports.
  logic pc_update;
  logic branch;
  logic ir_write_raw;
  logic mem_write_raw;
  logic reg_write_raw;

  // Next-state decode. The opcode is only looked at in DECODE and MEMADR.
  // The IR cannot change in those states.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = (TRAP_ON_ILLEGAL != 0) ? S_TRAP : S_FETCH;
        endcase
      end
      // opcode[5] separates stores (0100011) from loads (0000011).
      S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_TRAP:     state_d = S_TRAP;
      // Codes 12-15 are unreachable, so recover to FETCH from them.
      default:    state_d = S_FETCH;
    endcase
  end

  // State register with asynchronous return to FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Moore output decode. The only input-dependent terms are the mem_ready
  // gating in FETCH and the branch resolution on zero.
  always_comb begin
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    illegal_instr = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        ir_write_raw = mem_ready;
        pc_update    = mem_ready;
      end
      // Compute the branch target (OldPC + imm) speculatively.
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
      end
      // The write strobe stays high through the stall until memory accepts it.
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      // Write the branch target into the PC. PC+4 is formed for the link write.
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_TRAP: begin
        illegal_instr = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Enables are held low while reset is asserted. This holds even before the
  // first clock edge.
  assign PCWrite  = reset_n & (pc_update | (branch & zero));
  assign IRWrite  = reset_n & ir_write_raw;
  assign MemWrite = reset_n & mem_write_raw;
  assign RegWrite = reset_n & reg_write_raw;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm. The stimulus pushes hand-computed
// output vectors, and a negedge monitor compares them against the DUT.
module tb_multicycle_main_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reset0_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;

  // Instance a: TRAP_ON_ILLEGAL=1
  logic       pcw_a, adr_a, mw_a, irw_a, rw_a, ill_a;
  logic [1:0] rs_a, asa_a, asb_a, op_a;
  logic [3:0] st_a;
  // Instance b: TRAP_ON_ILLEGAL=0
  logic       pcw_b, adr_b, mw_b, irw_b, rw_b, ill_b;
  logic [1:0] rs_b, asa_b, asb_b, op_b;
  logic [3:0] st_b;

  always #5 clk = ~clk;

  multicycle_main_fsm #(.TRAP_ON_ILLEGAL(1)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .IRWrite(irw_a),
    .ResultSrc(rs_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .ALUOp(op_a),
    .RegWrite(rw_a), .illegal_instr(ill_a), .state(st_a)
  );

  multicycle_main_fsm #(.TRAP_ON_ILLEGAL(0)) dut_nt (
    .clk(clk), .reset_n(reset0_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(pcw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .IRWrite(irw_b),
    .ResultSrc(rs_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .ALUOp(op_b),
    .RegWrite(rw_b), .illegal_instr(ill_b), .state(st_b)
  );

  // Field order: state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  // ALUSrcA, ALUSrcB, ALUOp, RegWrite, illegal_instr
  logic [17:0] act_a, act_b;
  assign act_a = {st_a, pcw_a, adr_a, mw_a, irw_a, rs_a, asa_a, asb_a, op_a, rw_a, ill_a};
  assign act_b = {st_b, pcw_b, adr_b, mw_b, irw_b, rs_b, asa_b, asb_b, op_b, rw_b, ill_b};

  localparam logic [17:0] E_FR   = {4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_F0   = {4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_F1   = {4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_DEC  = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MADR = {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MRD  = {4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_MWB  = {4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] E_MWR  = {4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_EXR  = {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
  localparam logic [17:0] E_EXI  = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
  localparam logic [17:0] E_AWB  = {4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0};
  localparam logic [17:0] E_BEQ1 = {4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
  localparam logic [17:0] E_BEQ0 = {4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b0};
  localparam logic [17:0] E_JAL  = {4'd10, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b0, 1'b0};
  localparam logic [17:0] E_TRAP = {4'd11, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1};

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] ILL = 7'b1110011;

  typedef struct {
    logic        sel;
    logic [17:0] exp_v;
    string       name;
  } chk_t;

  chk_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Drive one cycle of inputs shortly after the rising edge and queue the expected outputs.
  task automatic step(input logic [6:0] op, input logic z, input logic mr,
                      input logic rn, input logic rn0, input logic sel,
                      input logic [17:0] e, input string nm);
    chk_t c;
    @(posedge clk);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    reset_n   = rn;
    reset0_n  = rn0;
    c.sel   = sel;
    c.exp_v = e;
    c.name  = nm;
    exp_q.push_back(c);
  endtask

  // Shorthand for instance a running normally, with instance b held in reset.
  task automatic s1(input logic [6:0] op, input logic z, input logic mr,
                    input logic [17:0] e, input string nm);
    step(op, z, mr, 1'b1, 1'b0, 1'b0, e, nm);
  endtask

  // Monitor: compare the selected instance's outputs mid-cycle.
  always @(negedge clk) begin
    chk_t        c;
    logic [17:0] got;
    if (exp_q.size() != 0) begin
      c   = exp_q.pop_front();
      got = c.sel ? act_b : act_a;
      n_checks++;
      if (got !== c.exp_v) begin
        n_fail++;
        $display("FAIL %s: dut%0d got=%05h expected=%05h", c.name, c.sel, got, c.exp_v);
      end else begin
        $display("check %s: dut%0d state=%0d outputs=%05h ok", c.name, c.sel, got[17:14], got);
      end
    end
  end

  initial begin
    int drain;
    reset_n   = 1'b0;
    reset0_n  = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // Reset hold: enables stay low even with mem_ready high.
    step(7'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_FR, "rst_hold");
    step(7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FR, "rst_hold_mr1");

    // lw with no stalls: 0,1,2,3,4
    s1(LW, 1'b0, 1'b1, E_F1,   "lw_fetch");
    s1(LW, 1'b0, 1'b1, E_DEC,  "lw_decode");
    s1(LW, 1'b0, 1'b1, E_MADR, "lw_memadr");
    s1(LW, 1'b0, 1'b1, E_MRD,  "lw_memread");
    s1(LW, 1'b0, 1'b1, E_MWB,  "lw_memwb");

    // sw with one fetch stall, then three MEMWRITE stalls.
    s1(SW, 1'b0, 1'b0, E_F0,   "sw_fetch_stall");
    s1(SW, 1'b0, 1'b1, E_F1,   "sw_fetch");
    s1(SW, 1'b0, 1'b1, E_DEC,  "sw_decode");
    s1(SW, 1'b0, 1'b1, E_MADR, "sw_memadr");
    s1(SW, 1'b0, 1'b0, E_MWR,  "sw_memwrite_stall1");
    s1(SW, 1'b0, 1'b0, E_MWR,  "sw_memwrite_stall2");
    s1(SW, 1'b0, 1'b0, E_MWR,  "sw_memwrite_stall3");
    s1(SW, 1'b0, 1'b1, E_MWR,  "sw_memwrite_done");

    // Reset asserted mid-MEMWRITE stall.
    s1(SW, 1'b0, 1'b1, E_F1,   "sw2_fetch");
    s1(SW, 1'b0, 1'b1, E_DEC,  "sw2_decode");
    s1(SW, 1'b0, 1'b1, E_MADR, "sw2_memadr");
    s1(SW, 1'b0, 1'b0, E_MWR,  "sw2_memwrite_stall");
    step(SW, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_FR, "rst_mid_memwrite");
    s1(SW, 1'b0, 1'b1, E_F1,   "post_rst_fetch");
    s1(SW, 1'b0, 1'b1, E_DEC,  "post_rst_decode");
    s1(SW, 1'b0, 1'b1, E_MADR, "post_rst_memadr");
    s1(SW, 1'b0, 1'b1, E_MWR,  "post_rst_memwrite");

    // R-type, then I-type.
    s1(RT, 1'b0, 1'b1, E_F1,   "r_fetch");
    s1(RT, 1'b0, 1'b1, E_DEC,  "r_decode");
    s1(RT, 1'b0, 1'b1, E_EXR,  "r_execute");
    s1(RT, 1'b0, 1'b1, E_AWB,  "r_aluwb");
    s1(IT, 1'b0, 1'b1, E_F1,   "i_fetch");
    s1(IT, 1'b0, 1'b1, E_DEC,  "i_decode");
    s1(IT, 1'b0, 1'b1, E_EXI,  "i_execute");
    s1(IT, 1'b0, 1'b1, E_AWB,  "i_aluwb");

    // beq taken and not taken.
    s1(BQ, 1'b0, 1'b1, E_F1,   "beq1_fetch");
    s1(BQ, 1'b0, 1'b1, E_DEC,  "beq1_decode");
    s1(BQ, 1'b1, 1'b1, E_BEQ1, "beq_taken");
    s1(BQ, 1'b0, 1'b1, E_F1,   "beq0_fetch");
    s1(BQ, 1'b1, 1'b1, E_DEC,  "beq0_decode");
    s1(BQ, 1'b0, 1'b1, E_BEQ0, "beq_not_taken");

    // jal: 0,1,10,8
    s1(JL, 1'b0, 1'b1, E_F1,   "jal_fetch");
    s1(JL, 1'b0, 1'b1, E_DEC,  "jal_decode");
    s1(JL, 1'b0, 1'b1, E_JAL,  "jal_jal");
    s1(JL, 1'b0, 1'b1, E_AWB,  "jal_aluwb");
    s1(JL, 1'b0, 1'b0, E_F0,   "jal_next_fetch");

    // TRAP_ON_ILLEGAL=0: an illegal opcode goes DECODE -> FETCH as a NOP. Instance a is held in reset.
    step(ILL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, E_F1,  "nt_fetch");
    step(ILL, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, E_DEC, "nt_decode");
    step(ILL, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, E_F0,  "nt_back_to_fetch");
    step(ILL, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, E_F1,  "nt_fetch_again");

    // TRAP_ON_ILLEGAL=1: an illegal opcode enters TRAP and stays there.
    s1(ILL, 1'b0, 1'b1, E_F1,  "trap_fetch");
    s1(ILL, 1'b0, 1'b1, E_DEC, "trap_decode");
    for (int i = 0; i < 12; i++) begin
      s1(ILL, i[0], 1'b1, E_TRAP, $sformatf("trap_hold%0d", i));
    end
    step(LW, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_FR, "trap_rst");
    s1(LW, 1'b0, 1'b1, E_F1,  "trap_exit_fetch");
    s1(LW, 1'b0, 1'b1, E_DEC, "trap_exit_decode");

    // Let the monitor drain the queue, with a bound on the wait.
    drain = 0;
    while (exp_q.size() != 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d checks pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
